// File: rtl/vec_div_sequencer.sv
// rtl/vec_div_sequencer.sv - feeds an N-element signed vector through one divider and buffers the results
// Optional feature macro: VEC_DIV_TIMEOUT_EN (WAIT-state timeout counter and err_timeout).
module vec_div_sequencer #(
  parameter int N       = 4,
  parameter int AW      = 2,
  parameter int DW      = 16,
  parameter int RW      = 32,
  parameter int TIMEOUT = 200
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          vec_wr_en,
  input  logic [AW-1:0] vec_wr_addr,
  input  logic [DW-1:0] vec_wr_data,
  input  logic [DW-1:0] divisor_in,
  input  logic          start,
  output logic [DW-1:0] s_axis_dividend_tdata,
  output logic          s_axis_dividend_tvalid,
  output logic [DW-1:0] s_axis_divisor_tdata,
  output logic          s_axis_divisor_tvalid,
  input  logic [RW-1:0] m_axis_dout_tdata,
  input  logic          m_axis_dout_tvalid,
  input  logic [AW-1:0] res_rd_addr,
  output logic [RW-1:0] res_rd_data,
  output logic          busy,
  output logic          done,
  output logic          err_div0,
  output logic          err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_STORE, S_FIN
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] vec [N];
  logic [RW-1:0] res [N];
  logic [DW-1:0] divisor_q;
  logic [DW-1:0] dividend_hold;
  logic [DW-1:0] divisor_hold;
  logic [RW-1:0] dout_hold;
  logic [AW-1:0] idx;
  logic          err_div0_q;
  logic          timeout_hit;
  logic          last_elem;

  assign last_elem = (idx == AW'(N - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CHECK;
      S_CHECK: state_nxt = (divisor_q == '0) ? S_FIN : S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        // a result arriving on the limit cycle still counts as an answer
        if (m_axis_dout_tvalid)  state_nxt = S_STORE;
        else if (timeout_hit)    state_nxt = S_FIN;
      end
      S_STORE: state_nxt = last_elem ? S_FIN : S_ISSUE;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // tdata is live from the buffer during ISSUE and holds the last issued operands otherwise
  assign s_axis_dividend_tvalid = (state == S_ISSUE);
  assign s_axis_divisor_tvalid  = (state == S_ISSUE);
  assign s_axis_dividend_tdata  = (state == S_ISSUE) ? vec[idx] : dividend_hold;
  assign s_axis_divisor_tdata   = (state == S_ISSUE) ? divisor_q : divisor_hold;
  assign busy     = (state == S_CHECK) || (state == S_ISSUE) ||
                    (state == S_WAIT)  || (state == S_STORE);
  assign done     = (state == S_FIN);
  assign err_div0 = err_div0_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= S_IDLE;
      idx           <= '0;
      divisor_q     <= '0;
      dividend_hold <= '0;
      divisor_hold  <= '0;
      dout_hold     <= '0;
      err_div0_q    <= 1'b0;
      res_rd_data   <= '0;
      for (int i = 0; i < N; i++) begin
        vec[i] <= '0;
        res[i] <= '0;
      end
    end else begin
      state       <= state_nxt;
      res_rd_data <= res[res_rd_addr];
      case (state)
        S_IDLE: begin
          if (vec_wr_en) vec[vec_wr_addr] <= vec_wr_data;
          if (start) begin
            divisor_q  <= divisor_in;
            err_div0_q <= 1'b0;
            idx        <= '0;
          end
        end
        S_CHECK: begin
          if (divisor_q == '0) begin
            err_div0_q <= 1'b1;
            for (int i = 0; i < N; i++) res[i] <= '0;
          end
        end
        S_ISSUE: begin
          dividend_hold <= vec[idx];
          divisor_hold  <= divisor_q;
        end
        S_WAIT: begin
          if (m_axis_dout_tvalid) dout_hold <= m_axis_dout_tdata;
        end
        S_STORE: begin
          res[idx] <= dout_hold;
          if (!last_elem) idx <= idx + AW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef VEC_DIV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;
  logic          err_timeout_q;

  // counter is 0 on the first WAIT cycle, so the last allowed cycle is TIMEOUT-1
  assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));
  assign err_timeout = err_timeout_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wait_cnt      <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      if (state == S_IDLE && start)
        err_timeout_q <= 1'b0;
      else if (state == S_WAIT && !m_axis_dout_tvalid && timeout_hit)
        err_timeout_q <= 1'b1;
      if (state == S_ISSUE)
        wait_cnt <= '0;
      else if (state == S_WAIT)
        wait_cnt <= wait_cnt + CW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_vec_div_sequencer.sv
// tb/tb_vec_div_sequencer.sv - self-checking bench for vec_div_sequencer with a 20-cycle divider model
`timescale 1ns/1ps
module tb_vec_div_sequencer;

  localparam int N = 4, AW = 2, DW = 16, RW = 32, TIMEOUT = 50, LD = 20;
  localparam int FULL_LAT = 2 + N * (2 + LD);

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          vec_wr_en = 1'b0;
  logic [AW-1:0] vec_wr_addr = '0;
  logic [DW-1:0] vec_wr_data = '0;
  logic [DW-1:0] divisor_in = '0;
  logic          start = 1'b0;
  logic [DW-1:0] s_axis_dividend_tdata;
  logic          s_axis_dividend_tvalid;
  logic [DW-1:0] s_axis_divisor_tdata;
  logic          s_axis_divisor_tvalid;
  logic [RW-1:0] m_axis_dout_tdata = '0;
  logic          m_axis_dout_tvalid = 1'b0;
  logic [AW-1:0] res_rd_addr = '0;
  logic [RW-1:0] res_rd_data;
  logic          busy, done, err_div0, err_timeout;

  always #5 aclk = ~aclk;

  vec_div_sequencer #(.N(N), .AW(AW), .DW(DW), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .vec_wr_en(vec_wr_en), .vec_wr_addr(vec_wr_addr), .vec_wr_data(vec_wr_data),
    .divisor_in(divisor_in), .start(start),
    .s_axis_dividend_tdata(s_axis_dividend_tdata), .s_axis_dividend_tvalid(s_axis_dividend_tvalid),
    .s_axis_divisor_tdata(s_axis_divisor_tdata), .s_axis_divisor_tvalid(s_axis_divisor_tvalid),
    .m_axis_dout_tdata(m_axis_dout_tdata), .m_axis_dout_tvalid(m_axis_dout_tvalid),
    .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data),
    .busy(busy), .done(done), .err_div0(err_div0), .err_timeout(err_timeout)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // reference: {quotient, remainder} with truncating signed division
  function automatic logic [RW-1:0] div_ref(input logic signed [DW-1:0] a,
                                            input logic signed [DW-1:0] b);
    logic signed [DW-1:0] q, r;
    if (b == 0) return '0;
    q = a / b;
    r = a % b;
    return {q, r};
  endfunction

  logic [DW-1:0] mvec [N];
  logic [RW-1:0] mres [N];
  logic [DW-1:0] mdiv = '0;
  int            tv_cnt = 0;
  bit            model_en = 1'b1;
  bit            spur_req = 1'b0;

  // divider model: answers LD cycles after the issue cycle
  initial begin : divider_model
    int            cd;
    logic [RW-1:0] pend;
    cd = 0;
    pend = '0;
    forever begin
      @(posedge aclk); #1;
      m_axis_dout_tvalid = 1'b0;
      if (!aresetn) cd = 0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          m_axis_dout_tvalid = 1'b1;
          m_axis_dout_tdata  = pend;
        end
      end
      if (spur_req) begin
        m_axis_dout_tvalid = 1'b1;
        m_axis_dout_tdata  = 32'hDEAD_BEEF;
        spur_req = 1'b0;
      end
      if (aresetn && (s_axis_dividend_tvalid || s_axis_divisor_tvalid)) begin
        check("tvalid_pair", s_axis_divisor_tvalid, s_axis_dividend_tvalid);
        if (tv_cnt < N) begin
          check($sformatf("issue_dividend%0d", tv_cnt), s_axis_dividend_tdata, mvec[tv_cnt]);
          check($sformatf("issue_divisor%0d", tv_cnt), s_axis_divisor_tdata, mdiv);
        end
        tv_cnt++;
        if (model_en) begin
          cd   = LD;
          pend = div_ref(s_axis_dividend_tdata, s_axis_divisor_tdata);
        end
      end
    end
  end

  task automatic write_vec(input int addr, input logic [DW-1:0] data);
    vec_wr_en   = 1'b1;
    vec_wr_addr = AW'(addr);
    vec_wr_data = data;
    @(posedge aclk); #1;
    vec_wr_en = 1'b0;
    mvec[addr] = data;
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < N; i++) begin
      res_rd_addr = AW'(i);
      @(posedge aclk); #1;
      check($sformatf("%s_res%0d", tag, i), res_rd_data, mres[i]);
    end
  endtask

  task automatic run_seq(input logic [DW-1:0] d, input bit inject, output int lat);
    mdiv       = d;
    tv_cnt     = 0;
    divisor_in = d;
    start      = 1'b1;
    lat        = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge aclk); #1;
      if (n == 1) begin
        start = 1'b0;
        check("flags_clear_on_start", {err_div0, err_timeout}, 2'b00);
        check("busy_after_start", busy, 1'b1);
      end
      if (inject && n == 30) begin
        start       = 1'b1;
        divisor_in  = '0;
        vec_wr_en   = 1'b1;
        vec_wr_addr = AW'(N - 1);
        vec_wr_data = ~mvec[N-1];
      end
      if (inject && n == 31) begin
        start      = 1'b0;
        vec_wr_en  = 1'b0;
        divisor_in = d;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    check("done_seen", lat >= 0, 1'b1);
    if (lat >= 0) begin
      check("busy_low_at_done", busy, 1'b0);
      @(posedge aclk); #1;
      check("done_one_cycle", done, 1'b0);
    end
  endtask

  typedef struct {
    logic [N-1:0][DW-1:0] v;
    logic [DW-1:0]        d;
    logic [N-1:0][RW-1:0] r;
    logic                 e0;
    int                   lat;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int lat;
    int ndone;
    logic [DW-1:0] d;

    tbl[0] = '{v: {16'h0007, 16'h0003, 16'hFFF8, 16'h0008}, d: 16'h0002,
               r: {32'h0003_0001, 32'h0001_0001, 32'hFFFC_0000, 32'h0004_0000},
               e0: 1'b0, lat: FULL_LAT};
    tbl[1] = '{v: {16'h0000, 16'hFFF9, 16'hFF9C, 16'h0064}, d: 16'hFFFD,
               r: {32'h0000_0000, 32'h0002_FFFF, 32'h0021_FFFF, 32'hFFDF_0001},
               e0: 1'b0, lat: FULL_LAT};
    tbl[2] = '{v: {16'h0008, 16'h0007, 16'h0006, 16'h0005}, d: 16'h0000,
               r: {32'h0, 32'h0, 32'h0, 32'h0}, e0: 1'b1, lat: 2};
    tbl[3] = '{v: {16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF}, d: 16'h0010,
               r: {32'h0000_FFFF, 32'h0000_0001, 32'hF800_0000, 32'h07FF_000F},
               e0: 1'b0, lat: FULL_LAT};

    for (int i = 0; i < N; i++) begin
      mvec[i] = '0;
      mres[i] = '0;
    end

    repeat (3) @(posedge aclk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tvalid", {s_axis_dividend_tvalid, s_axis_divisor_tvalid}, 2'b00);
    check("rst_tdata", {s_axis_dividend_tdata, s_axis_divisor_tdata}, 32'h0);
    check("rst_rd_data", res_rd_data, 32'h0);
    check("rst_errs", {err_div0, err_timeout}, 2'b00);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check_results("rst");

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) write_vec(i, tbl[t].v[i]);
      run_seq(tbl[t].d, 1'b0, lat);
      check($sformatf("tbl%0d_latency", t), lat, tbl[t].lat);
      check($sformatf("tbl%0d_issues", t), tv_cnt, tbl[t].e0 ? 0 : N);
      check($sformatf("tbl%0d_err_div0", t), err_div0, tbl[t].e0);
      if (!tbl[t].e0)
        check($sformatf("tbl%0d_tdata_hold", t), s_axis_dividend_tdata, mvec[N-1]);
      for (int i = 0; i < N; i++) mres[i] = tbl[t].r[i];
      check_results($sformatf("tbl%0d", t));
    end

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < N; i++) write_vec(i, DW'($urandom));
      d = DW'($urandom);
      if (t[0]) d = DW'($urandom_range(1, 9));
      if (d == '0) d = 16'h0001;
      run_seq(d, 1'b0, lat);
      check($sformatf("rnd%0d_latency", t), lat, FULL_LAT);
      check($sformatf("rnd%0d_issues", t), tv_cnt, N);
      for (int i = 0; i < N; i++) mres[i] = div_ref(mvec[i], d);
      check_results($sformatf("rnd%0d", t));
    end

    // start and writes during WAIT must be ignored
    for (int i = 0; i < N; i++) write_vec(i, DW'($urandom));
    d = 16'h0007;
    run_seq(d, 1'b1, lat);
    check("inject_latency", lat, FULL_LAT);
    check("inject_issues", tv_cnt, N);
    for (int i = 0; i < N; i++) mres[i] = div_ref(mvec[i], d);
    check_results("inject");

    // stray divider result while idle
    spur_req = 1'b1;
    ndone = 0;
    for (int n = 0; n < 4; n++) begin
      @(posedge aclk); #1;
      if (busy || done) ndone++;
    end
    check("spurious_no_activity", ndone, 0);
    check_results("spurious");

    // reset during the third element's WAIT
    for (int i = 0; i < N; i++) write_vec(i, DW'($urandom));
    mdiv = 16'h0005;
    divisor_in = mdiv;
    tv_cnt = 0;
    start = 1'b1;
    ndone = 0;
    for (int n = 1; n <= 55; n++) begin
      @(posedge aclk); #1;
      start = 1'b0;
      if (done) ndone++;
    end
    check("midrst_issues_before", tv_cnt, 3);
    aresetn = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_tvalid", {s_axis_dividend_tvalid, s_axis_divisor_tvalid}, 2'b00);
    check("midrst_tdata", {s_axis_dividend_tdata, s_axis_divisor_tdata}, 32'h0);
    check("midrst_rd_data", res_rd_data, 32'h0);
    for (int n = 0; n < 3; n++) begin
      @(posedge aclk); #1;
      if (done) ndone++;
    end
    aresetn = 1'b1;
    for (int n = 0; n < 25; n++) begin
      @(posedge aclk); #1;
      if (done || busy) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    for (int i = 0; i < N; i++) begin
      mvec[i] = '0;
      mres[i] = '0;
    end
    check_results("midrst_cleared");
    run_seq(16'h0003, 1'b0, lat);
    check("postrst_latency", lat, FULL_LAT);
    check_results("postrst_zero_vec");
    for (int i = 0; i < N; i++) write_vec(i, DW'($urandom));
    run_seq(16'hFFF5, 1'b0, lat);
    check("postrst2_latency", lat, FULL_LAT);
    for (int i = 0; i < N; i++) mres[i] = div_ref(mvec[i], 16'hFFF5);
    check_results("postrst2");

`ifdef VEC_DIV_TIMEOUT_EN
    model_en = 1'b0;
    run_seq(16'h0009, 1'b0, lat);
    check("timeout_latency_window", (lat >= TIMEOUT + 2) && (lat <= TIMEOUT + 4), 1'b1);
    check("timeout_flag", err_timeout, 1'b1);
    check("timeout_issues", tv_cnt, 1);
    check_results("timeout_kept");
    model_en = 1'b1;
    run_seq(16'h0009, 1'b0, lat);
    check("after_timeout_flag", err_timeout, 1'b0);
    check("after_timeout_latency", lat, FULL_LAT);
    for (int i = 0; i < N; i++) mres[i] = div_ref(mvec[i], 16'h0009);
    check_results("after_timeout");
`else
    check("timeout_tied_low", err_timeout, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit, expected completion");
    $fatal(1);
  end

endmodule
